// File: rtl/demo_pkg.sv
// Shared constants, state encoding and scene table for the demo sequencer.
package demo_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FADE_IN  = 2'd1;
    localparam logic [1:0] ST_PLAY     = 2'd2;
    localparam logic [1:0] ST_FADE_OUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        FADE_IN  = ST_FADE_IN,
        PLAY     = ST_PLAY,
        FADE_OUT = ST_FADE_OUT
    } state_e;

    localparam logic [3:0] VOL_MAX = 4'd15;

    // Scene index -> {channel mask s4..s1, effect select}.
    function automatic logic [5:0] scene_entry(input logic [2:0] scene);
        logic [5:0] e;
        case (scene)
            3'd0:    e = {4'b0001, 2'd0};
            3'd1:    e = {4'b0011, 2'd0};
            3'd2:    e = {4'b0111, 2'd1};
            3'd3:    e = {4'b1111, 2'd1};
            3'd4:    e = {4'b1110, 2'd2};
            3'd5:    e = {4'b1101, 2'd2};
            3'd6:    e = {4'b1011, 2'd3};
            default: e = {4'b1111, 2'd3};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/demo_sequencer_scene_rom.sv
// Combinational scene lookup; its outputs are registered by the parent.
module scene_rom
    import demo_pkg::*;
(
    input  logic [2:0] scene_i,
    output logic [3:0] mask_o,
    output logic [1:0] fx_o
);

    // Table lookup for the scene being entered or held.
    always_comb begin
        {mask_o, fx_o} = scene_entry(scene_i);
    end

endmodule

// File: rtl/demo_sequencer.sv
// Scene scheduler: walks the song order on bar ticks, ramps master volume
// on frame ticks, and drives channel mask / effect select per scene.
//
// Handshake: none. bar_tick and frame_tick are single-cycle strobes with no
// back-pressure; a strobe is consumed only by the state that uses it and only
// while pause is low. Every output comes straight from a register.
module demo_sequencer
    import demo_pkg::*;
#(
    parameter int NUM_SCENES     = 8,
    parameter int BARS_PER_SCENE = 4,
    parameter int LOOP_SCENE     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bar_tick,
    input  logic       frame_tick,
    input  logic       pause,
    output logic [2:0] scene_o,
    output logic [3:0] ch_mask,
    output logic [1:0] fx_sel,
    output logic [3:0] vol,
    output logic       scene_start,
    output logic [1:0] state_o
);

    localparam logic [2:0] SCENE_LAST = 3'(NUM_SCENES - 1);
    localparam logic [2:0] SCENE_LOOP = 3'(LOOP_SCENE);
    localparam logic [3:0] BAR_LAST   = 4'(BARS_PER_SCENE - 1);

    state_e     state_q, state_d;
    logic [2:0] scene_q, scene_d;
    logic [3:0] bar_cnt_q, bar_cnt_d;
    logic [3:0] vol_q, vol_d;
    logic       start_q, start_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] fx_q, fx_d;
    logic [3:0] rom_mask;
    logic [1:0] rom_fx;

    // Table entry for the scene that will be current after this edge.
    scene_rom u_scene_rom (
        .scene_i (scene_d),
        .mask_o  (rom_mask),
        .fx_o    (rom_fx)
    );

    // Next-state logic: timeline advance, volume ramp and scene entry pulse.
    always_comb begin
        state_d   = state_q;
        scene_d   = scene_q;
        bar_cnt_d = bar_cnt_q;
        vol_d     = vol_q;
        start_d   = 1'b0;
        if (!pause) begin
            case (state_q)
                IDLE: begin
                    if (bar_tick) begin
                        state_d   = FADE_IN;
                        scene_d   = 3'd0;
                        bar_cnt_d = 4'd0;
                        vol_d     = 4'd0;
                        start_d   = 1'b1;
                    end
                end
                FADE_IN: begin
                    if (frame_tick) begin
                        if (vol_q == VOL_MAX) begin
                            state_d   = PLAY;
                            bar_cnt_d = 4'd0;
                        end else begin
                            vol_d = vol_q + 4'd1;
                        end
                    end
                end
                PLAY: begin
                    if (bar_tick) begin
                        if (bar_cnt_q == BAR_LAST) begin
                            bar_cnt_d = 4'd0;
                            if (scene_q == SCENE_LAST) begin
                                state_d = FADE_OUT;
                            end else begin
                                scene_d = scene_q + 3'd1;
                                start_d = 1'b1;
                            end
                        end else begin
                            bar_cnt_d = bar_cnt_q + 4'd1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (vol_q == 4'd0) begin
                            state_d = FADE_IN;
                            scene_d = SCENE_LOOP;
                            start_d = 1'b1;
                        end else begin
                            vol_d = vol_q - 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Outputs are silent while idle, otherwise follow the scene table.
        if (state_d == IDLE) begin
            mask_d = 4'd0;
            fx_d   = 2'd0;
        end else begin
            mask_d = rom_mask;
            fx_d   = rom_fx;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            scene_q   <= 3'd0;
            bar_cnt_q <= 4'd0;
            vol_q     <= 4'd0;
            start_q   <= 1'b0;
            mask_q    <= 4'd0;
            fx_q      <= 2'd0;
        end else begin
            state_q   <= state_d;
            scene_q   <= scene_d;
            bar_cnt_q <= bar_cnt_d;
            vol_q     <= vol_d;
            start_q   <= start_d;
            mask_q    <= mask_d;
            fx_q      <= fx_d;
        end
    end

    assign scene_o     = scene_q;
    assign ch_mask     = mask_q;
    assign fx_sel      = fx_q;
    assign vol         = vol_q;
    assign scene_start = start_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Bench for demo_sequencer: constant vector table, directed corner
// sequences and randomized ticks checked against a behavioural model.
module tb_demo_sequencer;

    localparam int NUM_SCENES     = 8;
    localparam int BARS_PER_SCENE = 4;
    localparam int LOOP_SCENE     = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bar_tick = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] scene_o;
    logic [3:0] ch_mask;
    logic [1:0] fx_sel;
    logic [3:0] vol;
    logic       scene_start;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    demo_sequencer #(
        .NUM_SCENES     (NUM_SCENES),
        .BARS_PER_SCENE (BARS_PER_SCENE),
        .LOOP_SCENE     (LOOP_SCENE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bar_tick    (bar_tick),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .scene_o     (scene_o),
        .ch_mask     (ch_mask),
        .fx_sel      (fx_sel),
        .vol         (vol),
        .scene_start (scene_start),
        .state_o     (state_o)
    );

    // clock / reset
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE = 0, M_FADE_IN = 1, M_PLAY = 2, M_FADE_OUT = 3} mode_t;
    mode_t m_mode;
    int    m_scene, m_bars, m_vol;
    bit    m_start;
    logic [3:0] song_mask [8];
    logic [1:0] song_fx   [8];

    function automatic void model_reset();
        m_mode = M_IDLE; m_scene = 0; m_bars = 0; m_vol = 0; m_start = 0;
    endfunction

    function automatic void model_step(bit b, bit f, bit p);
        m_start = 0;
        if (p) return;
        case (m_mode)
            M_IDLE: if (b) begin
                m_mode = M_FADE_IN; m_scene = 0; m_vol = 0; m_bars = 0; m_start = 1;
            end
            M_FADE_IN: if (f) begin
                if (m_vol == 15) begin m_mode = M_PLAY; m_bars = 0; end
                else m_vol++;
            end
            M_PLAY: if (b) begin
                m_bars++;
                if (m_bars == BARS_PER_SCENE) begin
                    m_bars = 0;
                    if (m_scene == NUM_SCENES - 1) m_mode = M_FADE_OUT;
                    else begin m_scene++; m_start = 1; end
                end
            end
            M_FADE_OUT: if (f) begin
                if (m_vol == 0) begin m_mode = M_FADE_IN; m_scene = LOOP_SCENE; m_start = 1; end
                else m_vol--;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] model_out();
        logic [3:0] mk;
        logic [1:0] fx;
        mk = (m_mode == M_IDLE) ? 4'd0 : song_mask[m_scene];
        fx = (m_mode == M_IDLE) ? 2'd0 : song_fx[m_scene];
        return {2'(m_mode), 3'(m_scene), mk, fx, 4'(m_vol), m_start};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_out();
        return {state_o, scene_o, ch_mask, fx_sel, vol, scene_start};
    endfunction

    // ---------------- drivers ----------------
    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic cycle(input bit b, input bit f, input bit p, input string name);
        bar_tick = b; frame_tick = f; pause = p;
        model_step(b, f, p);
        @(posedge clock); #1;
        bar_tick = 0; frame_tick = 0; pause = 0;
        chk(name, 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic do_reset(input string name);
        reset = 1; bar_tick = 0; frame_tick = 0; pause = 0;
        @(posedge clock); #1;
        reset = 0;
        model_reset();
        chk(name, 32'(dut_out()), 32'd0);
    endtask

    typedef struct {
        bit         b, f, p;
        logic [1:0] st;
        logic [2:0] scene;
        logic [3:0] mask;
        logic [1:0] fx;
        logic [3:0] vol;
        logic       start;
    } vec_t;
    vec_t vecs [7];

    initial begin
        song_mask = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b1111};
        song_fx   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        vecs[0] = '{0, 0, 0, 2'd0, 3'd0, 4'b0000, 2'd0, 4'd0, 1'b0};
        vecs[1] = '{1, 0, 0, 2'd1, 3'd0, 4'b0001, 2'd0, 4'd0, 1'b1};
        vecs[2] = '{0, 1, 0, 2'd1, 3'd0, 4'b0001, 2'd0, 4'd1, 1'b0};
        vecs[3] = '{1, 1, 0, 2'd1, 3'd0, 4'b0001, 2'd0, 4'd2, 1'b0};
        vecs[4] = '{0, 1, 1, 2'd1, 3'd0, 4'b0001, 2'd0, 4'd2, 1'b0};
        vecs[5] = '{1, 0, 0, 2'd1, 3'd0, 4'b0001, 2'd0, 4'd2, 1'b0};
        vecs[6] = '{0, 1, 0, 2'd1, 3'd0, 4'b0001, 2'd0, 4'd3, 1'b0};

        repeat (3) @(posedge clock);
        #1;

        // Table-driven vectors from reset.
        do_reset("tbl_reset");
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].b, vecs[i].f, vecs[i].p, "tbl_model");
            chk($sformatf("tbl_vec%0d", i), 32'(dut_out()),
                32'({vecs[i].st, vecs[i].scene, vecs[i].mask, vecs[i].fx, vecs[i].vol, vecs[i].start}));
        end

        // 1: idle for 100 cycles, then the first bar starts scene 0.
        do_reset("t1_reset");
        repeat (100) cycle(0, 0, 0, "t1_idle");
        chk("t1_idle_zero", 32'(dut_out()), 32'd0);
        cycle(1, 0, 0, "t1_start");
        chk("t1_start_vec", 32'(dut_out()), 32'({2'd1, 3'd0, 4'b0001, 2'd0, 4'd0, 1'b1}));

        // 2: fade in with bars mixed in; 16th frame enters PLAY.
        for (int i = 0; i < 15; i++) cycle(i % 3 == 0, 1, 0, "t2_fade");
        chk("t2_vol15", 32'({state_o, scene_o, vol}), 32'({2'd1, 3'd0, 4'd15}));
        cycle(0, 1, 0, "t2_play");
        chk("t2_play_vec", 32'({state_o, vol}), 32'({2'd2, 4'd15}));

        // 3: three bars hold, fourth bar advances to scene 1.
        repeat (3) cycle(1, 0, 0, "t3_bars");
        chk("t3_hold", 32'({scene_o, scene_start}), 32'({3'd0, 1'b0}));
        cycle(1, 0, 0, "t3_adv");
        chk("t3_adv_vec", 32'({scene_o, ch_mask, fx_sel, scene_start}), 32'({3'd1, 4'b0011, 2'd0, 1'b1}));
        cycle(0, 1, 0, "t3_pulse_end");
        chk("t3_pulse_end_vec", 32'({scene_start, vol}), 32'({1'b0, 4'd15}));

        // 4: run to scene 7, fade out, loop back to LOOP_SCENE.
        for (int i = 0; i < 24; i++) cycle(1, 0, 0, "t4_walk");
        chk("t4_scene7", 32'({scene_o, ch_mask, fx_sel}), 32'({3'd7, 4'b1111, 2'd3}));
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, "t4_last");
        chk("t4_fadeout", 32'({state_o, scene_o, scene_start}), 32'({2'd3, 3'd7, 1'b0}));
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, "t4_fade");
        chk("t4_vol0", 32'({state_o, vol}), 32'({2'd3, 4'd0}));
        cycle(0, 1, 0, "t4_loop");
        chk("t4_loop_vec", 32'(dut_out()), 32'({2'd1, 3'd1, 4'b0011, 2'd0, 4'd0, 1'b1}));

        // 5: simultaneous ticks in FADE_IN, then pause over mixed ticks.
        cycle(1, 1, 0, "t5_both");
        chk("t5_both_vec", 32'({state_o, scene_o, vol}), 32'({2'd1, 3'd1, 4'd1}));
        for (int i = 0; i < 10; i++) begin
            cycle(i % 2 == 0, i % 3 != 0, 1, "t5_pause");
            chk("t5_pause_const", 32'(dut_out()), 32'({2'd1, 3'd1, 4'b0011, 2'd0, 4'd1, 1'b0}));
        end

        // 6: reset in PLAY at scene 3 with two bars counted.
        for (int i = 0; i < 40 && m_mode != M_PLAY; i++) cycle(0, 1, 0, "t6_ramp");
        for (int i = 0; i < 40 && !(m_scene == 3 && m_bars == 2); i++) cycle(1, 0, 0, "t6_walk");
        chk("t6_at_scene3", 32'({state_o, scene_o}), 32'({2'd2, 3'd3}));
        do_reset("t6_reset");
        cycle(1, 0, 0, "t6_restart");
        chk("t6_restart_vec", 32'({state_o, scene_o, scene_start}), 32'({2'd1, 3'd0, 1'b1}));

        // Randomized ticks, pauses and occasional resets against the model.
        do_reset("rnd_reset");
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                do_reset("rnd_mid_reset");
            end else begin
                cycle($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15) == 0, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
